// File: rtl/switch_press_conditioner_if.sv
// Press handshake between the switch conditioner and the puzzle core.
// One-hot press index offered with valid, accepted with ready.
interface switch_press_conditioner_if;
  logic [7:0] press_onehot;
  logic       press_valid;
  logic       press_ready;

  modport master (
    output press_onehot,
    output press_valid,
    input  press_ready
  );

  modport slave (
    input  press_onehot,
    input  press_valid,
    output press_ready
  );
endinterface

// File: rtl/switch_press_conditioner.sv
// Switch front end: sync, debounce, rising-edge press events,
// per-switch pending queue and one-hot press handshake.
module switch_press_conditioner #(
  parameter  int DEBOUNCE_CYCLES = 1000000,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sw_raw,
  output logic [7:0] stable_sw,
  output logic       overflow,
  switch_press_conditioner_if.master press_if
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       r_sync1;
  logic [7:0]       r_sync2;
  logic [7:0]       r_stable;
  logic [CNT_W-1:0] r_cnt [8];
  logic [7:0]       r_pending;
  logic [7:0]       r_onehot;
  logic             r_valid;
  logic             r_ovf;

  logic [7:0] w_flip;
  logic [7:0] w_rise;
  logic [7:0] w_pick;
  logic [7:0] w_take;
  logic [7:0] w_drop;
  logic       w_load;

  // A bit flips once it has differed for the full debounce window
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < 8; i++) begin
      w_flip[i] = (r_sync2[i] != r_stable[i]) &&
                  (r_cnt[i] == CNT_MAX);
    end
  end

  assign w_rise = w_flip & ~r_stable;
  assign w_load = !r_valid || press_if.press_ready;
  assign w_pick = r_pending & (~r_pending + 8'd1);
  assign w_take = w_load ? w_pick : 8'd0;
  assign w_drop = w_rise & r_pending & ~w_take;

  // Two-flop synchroniser on the raw switch levels
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-bit debounce counter; any return to stable restarts it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable <= '0;
      for (int i = 0; i < 8; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_flip[i]) begin
          r_stable[i] <= ~r_stable[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Pending presses: set on rising flip, cleared when loaded
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_take) | w_rise;
      if (w_drop != 8'd0) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Output stage: lowest pending switch first, holds while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      r_onehot <= '0;
      r_valid  <= 1'b0;
    end else if (w_load) begin
      r_onehot <= w_pick;
      r_valid  <= (r_pending != 8'd0);
    end
  end

  assign stable_sw             = r_stable;
  assign overflow              = r_ovf;
  assign press_if.press_onehot = r_onehot;
  assign press_if.press_valid  = r_valid;

endmodule

// File: tb/tb_switch_press_conditioner.sv
// Scoreboard bench: behavioural model predicts every transfer,
// monitor pops and compares on each valid/ready handshake.
module tb_switch_press_conditioner;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sw_raw = 8'd0;
  logic [7:0] stable_sw;
  logic       overflow;

  switch_press_conditioner_if pif();

  switch_press_conditioner #(
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_raw   (sw_raw),
    .stable_sw(stable_sw),
    .overflow (overflow),
    .press_if (pif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int xfers = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model state
  logic [7:0] m_s1 = 0, m_s2 = 0, m_st = 0;
  logic [7:0] m_pend = 0, m_oh = 0;
  logic       m_v = 0, m_ovf = 0;
  int         m_streak [8];
  bit         live = 0;
  logic [7:0] expq [$];

  // Model: checks current outputs, then advances one clock edge
  always @(negedge clk) begin : model
    logic [7:0] rise;
    int k;
    if (live) begin
      chk("stable_sw", 32'(stable_sw), 32'(m_st));
      chk("press_valid", 32'(pif.press_valid), 32'(m_v));
      chk("press_onehot", 32'(pif.press_onehot), 32'(m_oh));
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_st = 0;
      m_pend = 0; m_oh = 0; m_v = 0; m_ovf = 0;
      for (int i = 0; i < 8; i++) m_streak[i] = 0;
      live = 1;
    end else begin
      rise = 0;
      for (int i = 0; i < 8; i++) begin
        if (m_s2[i] != m_st[i]) begin
          m_streak[i]++;
          if (m_streak[i] == DEB) begin
            m_st[i] = ~m_st[i];
            m_streak[i] = 0;
            if (m_st[i]) rise[i] = 1'b1;
          end
        end else begin
          m_streak[i] = 0;
        end
      end
      if (m_v && pif.press_ready) expq.push_back(m_oh);
      if (!m_v || pif.press_ready) begin
        k = -1;
        for (int j = 7; j >= 0; j--) if (m_pend[j]) k = j;
        if (k >= 0) begin
          m_oh = 8'(1 << k);
          m_v = 1;
          m_pend[k] = 1'b0;
        end else begin
          m_oh = 0;
          m_v = 0;
        end
      end
      for (int i = 0; i < 8; i++) begin
        if (rise[i]) begin
          if (m_pend[i]) m_ovf = 1;
          m_pend[i] = 1'b1;
        end
      end
      m_s2 = m_s1;
      m_s1 = sw_raw;
    end
  end

  // Monitor: compare each handshake against the scoreboard
  initial begin : monitor
    logic v, r, rs;
    logic [7:0] oh, req;
    forever begin
      @(negedge clk);
      v = pif.press_valid;
      r = pif.press_ready;
      oh = pif.press_onehot;
      rs = reset;
      @(posedge clk);
      #1;
      if (v === 1'b1 && r === 1'b1 && !rs) begin
        xfers++;
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL transfer actual=%h required=none", oh);
        end else begin
          req = expq.pop_front();
          chk("transfer", 32'(oh), 32'(req));
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : stim
    int x0;
    pif.press_ready = 1'b0;
    // T1 reset
    reset = 1'b1;
    cyc(3);
    chk("t1_stable", 32'(stable_sw), 0);
    chk("t1_valid", 32'(pif.press_valid), 0);
    chk("t1_onehot", 32'(pif.press_onehot), 0);
    chk("t1_ovf", 32'(overflow), 0);
    reset = 1'b0;
    // T2 single press
    x0 = xfers;
    pif.press_ready = 1'b1;
    sw_raw = 8'h04;
    cyc(12);
    chk("t2_stable", 32'(stable_sw), 32'h04);
    chk("t2_xfers", 32'(xfers - x0), 1);
    sw_raw = 8'h00;
    cyc(10);
    // T3 bounce shorter than the window
    x0 = xfers;
    for (int k = 0; k < 10; k++) begin
      sw_raw = (k % 2 == 0) ? 8'h01 : 8'h00;
      cyc(2);
    end
    sw_raw = 8'h00;
    cyc(10);
    chk("t3_stable", 32'(stable_sw), 0);
    chk("t3_xfers", 32'(xfers - x0), 0);
    // T4 three simultaneous presses with stall
    x0 = xfers;
    pif.press_ready = 1'b0;
    sw_raw = 8'h91;
    cyc(10);
    chk("t4_stall_oh", 32'(pif.press_onehot), 32'h01);
    chk("t4_stall_v", 32'(pif.press_valid), 1);
    pif.press_ready = 1'b1;
    cyc(10);
    chk("t4_xfers", 32'(xfers - x0), 3);
    sw_raw = 8'h00;
    cyc(10);
    // T5 overflow on third press of one switch
    x0 = xfers;
    pif.press_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sw_raw = 8'h08;
      cyc(6);
      sw_raw = 8'h00;
      cyc(6);
    end
    chk("t5_ovf", 32'(overflow), 1);
    pif.press_ready = 1'b1;
    cyc(6);
    chk("t5_xfers", 32'(xfers - x0), 2);
    // T6 reset mid-handshake and mid-debounce
    pif.press_ready = 1'b0;
    sw_raw = 8'h02;
    cyc(8);
    sw_raw = 8'h22;
    cyc(3);
    reset = 1'b1;
    sw_raw = 8'h00;
    cyc(1);
    chk("t6_valid", 32'(pif.press_valid), 0);
    chk("t6_onehot", 32'(pif.press_onehot), 0);
    chk("t6_stable", 32'(stable_sw), 0);
    chk("t6_ovf", 32'(overflow), 0);
    reset = 1'b0;
    x0 = xfers;
    pif.press_ready = 1'b1;
    cyc(15);
    chk("t6_xfers", 32'(xfers - x0), 0);
    // Random switch activity, ready and occasional reset
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 5) == 0)
        sw_raw = sw_raw ^ 8'(1 << $urandom_range(0, 7));
      pif.press_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 999) == 0);
      cyc(1);
    end
    reset = 1'b0;
    sw_raw = 8'h00;
    pif.press_ready = 1'b1;
    cyc(40);
    chk("queue_empty", 32'(expq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
